lane_dispatcher: RTL

LANE_DISPATCHER -- requirements
Module: lane_dispatcher

---
 rtl/lane_dispatcher_pkg.sv | 33 +++
 rtl/lane_dispatcher_sync_fifo.sv | 85 ++++++++
 rtl/lane_dispatcher.sv | 85 ++++++++
 3 files changed

// File: rtl/lane_dispatcher_pkg.sv
// Shared constants and helpers for the lane dispatcher.
//   DEF_NUM_LANES / DEF_DATA_W / DEF_FIFO_DEPTH : default parameter values
//   MAX_LANES, lane_idx_t                       : lane index type wide enough for any legal lane count
//   idx_width()                                 : index width for n items, never below 1 bit
//   next_lane()                                 : round-robin successor with wrap at num_lanes-1
package lane_dispatcher_pkg;

   localparam int unsigned DEF_NUM_LANES  = 3;
   localparam int unsigned DEF_DATA_W     = 8;
   localparam int unsigned DEF_FIFO_DEPTH = 4;

   localparam int unsigned MAX_LANES  = 8;
   localparam int unsigned LANE_IDX_W = $clog2(MAX_LANES);

   typedef logic [LANE_IDX_W-1:0] lane_idx_t;

   // Width of an index over n items; a single item still needs one bit of storage.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Round-robin successor: wraps the last lane back to lane 0.
   function automatic lane_idx_t next_lane(input lane_idx_t cur, input int unsigned num_lanes);
      lane_idx_t nxt;
      if (32'(cur) >= (num_lanes - 1)) begin
         nxt = '0;
      end else begin
         nxt = lane_idx_t'(cur + lane_idx_t'(1));
      end
      return nxt;
   endfunction

endpackage

// File: rtl/lane_dispatcher_sync_fifo.sv
// Synchronous FIFO used as the dispatcher input buffer.
//   clk, rst       : clock, asynchronous active-high reset
//   push, wdata    : write request and payload (ignored while full)
//   pop            : read request (ignored while empty)
//   rdata          : head-of-queue payload, valid while !empty
//   full, empty    : occupancy flags decided from count
//   count          : current occupancy, 0..DEPTH
module sync_fifo
   import lane_dispatcher_pkg::*;
#(
   parameter  int unsigned DATA_W = DEF_DATA_W,
   parameter  int unsigned DEPTH  = DEF_FIFO_DEPTH,
   localparam int unsigned PTR_W  = idx_width(DEPTH),
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic do_push;
   logic do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem[rptr_q];

   // Requests are qualified here so the FIFO can never over- or under-run.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer/occupancy state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Next pointer/occupancy; pointers wrap explicitly at DEPTH-1.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;

      if (do_push) begin
         wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(wptr_q + PTR_W'(1));
      end
      if (do_pop) begin
         rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(rptr_q + PTR_W'(1));
      end

      unique case ({do_push, do_pop})
         2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
         2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
         default: count_d = count_q;
      endcase
   end

   // Storage carries no reset; contents behind the read pointer are don't-care.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/lane_dispatcher.sv
// Buffers an upstream word stream and hands words to NUM_LANES downstream lanes
// in strict round-robin order; a stalled lane holds the rotation.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : upstream word present
//   in_ready   : buffer can accept a word (low while full or in reset)
//   in_data    : upstream payload
//   out_valid  : one-hot valid, only the targeted lane, only when a word is buffered
//   out_ready  : per-lane ready; only the targeted lane's bit matters
//   out_data   : head-of-buffer payload broadcast to every lane
//   count      : buffer occupancy
//   lane_sel   : lane currently targeted
module lane_dispatcher
   import lane_dispatcher_pkg::*;
#(
   parameter  int unsigned NUM_LANES  = DEF_NUM_LANES,
   parameter  int unsigned DATA_W     = DEF_DATA_W,
   parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int unsigned LANE_W     = idx_width(NUM_LANES),
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   output logic [NUM_LANES-1:0] out_valid,
   input  logic [NUM_LANES-1:0] out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic [CNT_W-1:0]     count,
   output logic [LANE_W-1:0]    lane_sel
);

   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [LANE_W-1:0] lane_q, lane_d;

   // No push while full, even when a pop happens in the same cycle.
   assign in_ready = !full && !rst;
   assign push     = in_valid && in_ready;

   // out_valid is already one-hot at the targeted lane, so masking ignores the others.
   assign pop      = |(out_valid & out_ready);

   assign lane_sel = lane_q;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (in_data),
      .pop   (pop),
      .rdata (out_data),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Round-robin lane pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q <= '0;
      end else begin
         lane_q <= lane_d;
      end
   end

   // Advance only on a completed hand-off so a stalled lane is never skipped.
   always_comb begin
      lane_d = lane_q;
      if (pop) begin
         lane_d = LANE_W'(next_lane(lane_idx_t'(lane_q), NUM_LANES));
      end
   end

   // One-hot valid decode.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign out_valid[i] = !empty && (lane_q == LANE_W'(i));
   end

endmodule
